// File: rtl/eth_rx_buf_pkg.sv
// Shared types for the Ethernet RX store-and-forward packet buffer:
// Avalon-ST widths, write-FSM states and the stored word layout.
package eth_rx_buf_pkg;

    localparam int DATA_W  = 256;
    localparam int EMPTY_W = 5;
    localparam int ERR_W   = 6;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_RECV,
        WR_DROP
    } wr_state_e;

    typedef struct packed {
        logic [DATA_W-1:0]  data;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
    } ram_entry_t;

endpackage

// File: rtl/eth_rx_buf_ram.sv
// Simple dual-port packet storage with a registered read port; the read
// register holds its value whenever rd_en is low. Contents are never reset.
module eth_rx_buf_ram
    import eth_rx_buf_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  ram_entry_t    wr_entry,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output ram_entry_t    rd_entry
);

    ram_entry_t mem [DEPTH];
    ram_entry_t rd_entry_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_entry_q <= mem[rd_addr];
        end
    end

    assign rd_entry = rd_entry_q;

endmodule

// File: rtl/eth_rx_pkt_buffer.sv
// Store-and-forward RX packet buffer: packets become visible on the source
// only once their eop word is committed; errored or overflowing packets are dropped.
module eth_rx_pkt_buffer
    import eth_rx_buf_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [DATA_W-1:0]  rx_data_in,
    input  logic               rx_valid_in,
    input  logic               rx_sop_in,
    input  logic               rx_eop_in,
    input  logic [EMPTY_W-1:0] rx_empty_in,
    input  logic [ERR_W-1:0]   rx_error_in,
    output logic               rx_ready_out,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_sop,
    output logic               out_eop,
    output logic [EMPTY_W-1:0] out_empty,
    input  logic               out_ready,
    output logic [31:0]        pkt_cnt,
    output logic [31:0]        drop_err_cnt,
    output logic [31:0]        drop_ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL_OCC = PW'(DEPTH);

    wr_state_e     state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          err_acc_q, err_acc_d;
    logic [31:0]   pkt_cnt_q, pkt_cnt_d, drop_err_cnt_q, drop_err_cnt_d;
    logic [31:0]   drop_ovf_cnt_q, drop_ovf_cnt_d;
    logic [1:0]    err_inc;
    logic          wr_en, rd_en, load_out, data_avail, err_word;
    logic [AW-1:0] wr_addr;
    logic [PW-1:0] occ_wr, occ_base;
    ram_entry_t    wr_entry, rd_entry, out_entry_q, out_entry_d;
    logic          ram_vld_q, ram_vld_d, out_valid_q, out_valid_d;
    logic          out_sop_q, out_sop_d, first_q, first_d;

    assign rx_ready_out = reset_n;
    assign err_word     = |rx_error_in;
    assign occ_wr       = wr_ptr_q - rd_ptr_q;
    assign occ_base     = commit_ptr_q - rd_ptr_q;
    assign wr_entry     = '{data: rx_data_in, eop: rx_eop_in, empty: rx_empty_in};

    // A sop always restarts at commit_ptr, so an unterminated packet in RECV is discarded.
    always_comb begin
        state_d        = state_q;
        wr_ptr_d       = wr_ptr_q;
        commit_ptr_d   = commit_ptr_q;
        err_acc_d      = err_acc_q;
        pkt_cnt_d      = pkt_cnt_q;
        drop_ovf_cnt_d = drop_ovf_cnt_q;
        err_inc        = 2'd0;
        wr_en          = 1'b0;
        wr_addr        = wr_ptr_q[AW-1:0];
        if (rx_valid_in) begin
            if (rx_sop_in) begin
                if (state_q == WR_RECV) begin
                    err_inc = err_inc + 2'd1;
                end
                wr_ptr_d = commit_ptr_q;
                wr_addr  = commit_ptr_q[AW-1:0];
                if (occ_base == FULL_OCC) begin
                    drop_ovf_cnt_d = drop_ovf_cnt_q + 32'd1;
                    state_d        = rx_eop_in ? WR_IDLE : WR_DROP;
                end else begin
                    wr_en = 1'b1;
                    if (rx_eop_in) begin
                        state_d = WR_IDLE;
                        if (err_word) begin
                            err_inc = err_inc + 2'd1;
                        end else begin
                            wr_ptr_d     = commit_ptr_q + PW'(1);
                            commit_ptr_d = commit_ptr_q + PW'(1);
                            pkt_cnt_d    = pkt_cnt_q + 32'd1;
                        end
                    end else begin
                        wr_ptr_d  = commit_ptr_q + PW'(1);
                        err_acc_d = err_word;
                        state_d   = WR_RECV;
                    end
                end
            end else if (state_q == WR_RECV) begin
                if (occ_wr == FULL_OCC) begin
                    wr_ptr_d       = commit_ptr_q;
                    drop_ovf_cnt_d = drop_ovf_cnt_q + 32'd1;
                    state_d        = rx_eop_in ? WR_IDLE : WR_DROP;
                end else begin
                    wr_en = 1'b1;
                    if (rx_eop_in) begin
                        state_d = WR_IDLE;
                        if (err_acc_q || err_word) begin
                            wr_ptr_d = commit_ptr_q;
                            err_inc  = err_inc + 2'd1;
                        end else begin
                            wr_ptr_d     = wr_ptr_q + PW'(1);
                            commit_ptr_d = wr_ptr_q + PW'(1);
                            pkt_cnt_d    = pkt_cnt_q + 32'd1;
                        end
                    end else begin
                        wr_ptr_d  = wr_ptr_q + PW'(1);
                        err_acc_d = err_acc_q | err_word;
                    end
                end
            end else if (state_q == WR_DROP && rx_eop_in) begin
                state_d = WR_IDLE;
            end
        end
        drop_err_cnt_d = drop_err_cnt_q + {30'd0, err_inc};
    end

    // The RAM read register is the first pipeline stage; it stalls in place
    // when the output register cannot take its word.
    assign data_avail = (rd_ptr_q != commit_ptr_q);
    assign load_out   = ram_vld_q && (!out_valid_q || out_ready);
    assign rd_en      = data_avail && (!ram_vld_q || load_out);

    always_comb begin
        rd_ptr_d    = rd_en ? rd_ptr_q + PW'(1) : rd_ptr_q;
        ram_vld_d   = rd_en || (ram_vld_q && !load_out);
        out_valid_d = load_out || (out_valid_q && !out_ready);
        out_entry_d = load_out ? rd_entry : out_entry_q;
        out_sop_d   = load_out ? first_q : out_sop_q;
        first_d     = load_out ? rd_entry.eop : first_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= WR_IDLE;
            wr_ptr_q       <= '0;
            commit_ptr_q   <= '0;
            rd_ptr_q       <= '0;
            err_acc_q      <= 1'b0;
            pkt_cnt_q      <= '0;
            drop_err_cnt_q <= '0;
            drop_ovf_cnt_q <= '0;
            ram_vld_q      <= 1'b0;
            out_valid_q    <= 1'b0;
            out_entry_q    <= '0;
            out_sop_q      <= 1'b0;
            first_q        <= 1'b1;
        end else begin
            state_q        <= state_d;
            wr_ptr_q       <= wr_ptr_d;
            commit_ptr_q   <= commit_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            err_acc_q      <= err_acc_d;
            pkt_cnt_q      <= pkt_cnt_d;
            drop_err_cnt_q <= drop_err_cnt_d;
            drop_ovf_cnt_q <= drop_ovf_cnt_d;
            ram_vld_q      <= ram_vld_d;
            out_valid_q    <= out_valid_d;
            out_entry_q    <= out_entry_d;
            out_sop_q      <= out_sop_d;
            first_q        <= first_d;
        end
    end

    eth_rx_buf_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk      (clk),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_entry (wr_entry),
        .rd_en    (rd_en),
        .rd_addr  (rd_ptr_q[AW-1:0]),
        .rd_entry (rd_entry)
    );

    assign out_data     = out_entry_q.data;
    assign out_eop      = out_entry_q.eop;
    assign out_empty    = out_entry_q.empty;
    assign out_valid    = out_valid_q;
    assign out_sop      = out_sop_q;
    assign pkt_cnt      = pkt_cnt_q;
    assign drop_err_cnt = drop_err_cnt_q;
    assign drop_ovf_cnt = drop_ovf_cnt_q;

endmodule

// File: tb/tb_eth_rx_pkt_buffer.sv
// Directed self-checking bench for eth_rx_pkt_buffer: latency, error and
// overflow drops, framing errors, stalled output and mid-packet reset.
module tb_eth_rx_pkt_buffer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [255:0] rx_data_in;
    logic         rx_valid_in, rx_sop_in, rx_eop_in;
    logic [4:0]   rx_empty_in;
    logic [5:0]   rx_error_in;
    logic         rx_ready_out;
    logic [255:0] out_data;
    logic         out_valid, out_sop, out_eop;
    logic [4:0]   out_empty;
    logic         out_ready;
    logic [31:0]  pkt_cnt, drop_err_cnt, drop_ovf_cnt;

    int num_checks = 0;
    int num_fails  = 0;
    bit toggle_mode = 1'b0;

    logic [262:0] exp_q [$];
    logic [262:0] got_q [$];
    logic         prev_ok = 1'b0, prev_valid = 1'b0, prev_ready = 1'b0;
    logic [262:0] prev_word = '0;

    always #5 clk = ~clk;

    eth_rx_pkt_buffer #(.DEPTH(64)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx_data_in   (rx_data_in),
        .rx_valid_in  (rx_valid_in),
        .rx_sop_in    (rx_sop_in),
        .rx_eop_in    (rx_eop_in),
        .rx_empty_in  (rx_empty_in),
        .rx_error_in  (rx_error_in),
        .rx_ready_out (rx_ready_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_empty    (out_empty),
        .out_ready    (out_ready),
        .pkt_cnt      (pkt_cnt),
        .drop_err_cnt (drop_err_cnt),
        .drop_ovf_cnt (drop_ovf_cnt)
    );

    task automatic checkOutput(input string tag, input logic [262:0] observed,
                               input logic [262:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fails++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [255:0] mkData(input int p, input int w);
        logic [31:0] t;
        t = {p[15:0], w[15:0]};
        return {8{t}};
    endfunction

    // Drives one input beat, then advances one clock edge (returns #1 after it).
    task automatic applyStimulus(input logic v, input logic s, input logic e,
                                 input logic [4:0] emp, input logic [5:0] err,
                                 input logic [255:0] d);
        rx_valid_in = v;
        rx_sop_in   = s;
        rx_eop_in   = e;
        rx_empty_in = emp;
        rx_error_in = err;
        rx_data_in  = d;
        if (toggle_mode) out_ready = ~out_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, '0);
    endtask

    task automatic sendPacket(input int id, input int n, input logic [5:0] err_eop,
                              input logic [4:0] emp, input bit expect_it);
        for (int w = 0; w < n; w++) begin
            logic last;
            logic [4:0] e;
            last = (w == n - 1);
            e    = last ? emp : 5'd0;
            applyStimulus(1'b1, w == 0, last, e, last ? err_eop : 6'd0, mkData(id, w));
            if (expect_it) exp_q.push_back({w == 0, last, e, mkData(id, w)});
        end
    endtask

    task automatic drainCheck();
        int guard;
        guard = 0;
        rx_valid_in = 1'b0;
        while (got_q.size() < exp_q.size() && guard < 1000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        checkOutput("word_count", 263'(got_q.size()), 263'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            checkOutput("word_content", got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    // Output monitor: records accepted words and checks that a stalled word holds.
    always @(negedge clk) begin
        if (reset_n && prev_ok && prev_valid && !prev_ready) begin
            checkOutput("stall_valid", 263'(out_valid), 263'(1));
            checkOutput("stall_hold", {out_sop, out_eop, out_empty, out_data}, prev_word);
        end
        if (reset_n && out_valid && out_ready)
            got_q.push_back({out_sop, out_eop, out_empty, out_data});
        prev_ok    <= reset_n;
        prev_valid <= out_valid;
        prev_ready <= out_ready;
        prev_word  <= {out_sop, out_eop, out_empty, out_data};
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        out_ready   = 1'b1;
        rx_valid_in = 1'b0;
        rx_sop_in   = 1'b0;
        rx_eop_in   = 1'b0;
        rx_empty_in = '0;
        rx_error_in = '0;
        rx_data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 263'(out_valid), 263'(0));
        checkOutput("rst_out_flags", 263'({out_sop, out_eop, out_empty}), 263'(0));
        checkOutput("rst_out_data", 263'(out_data), 263'(0));
        checkOutput("rst_rx_ready", 263'(rx_ready_out), 263'(0));
        checkOutput("rst_counters", 263'({pkt_cnt, drop_err_cnt, drop_ovf_cnt}), 263'(0));
        reset_n = 1'b1;
        #1;
        checkOutput("rx_ready_high", 263'(rx_ready_out), 263'(1));
        idleCycles(2);

        $display("[TB] 4-word packet latency");
        sendPacket(1, 4, 6'd0, 5'd7, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, '0);
        checkOutput("lat_n1_valid", 263'(out_valid), 263'(0));
        for (int w = 0; w < 4; w++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 6'd0, '0);
            checkOutput("lat_valid", 263'(out_valid), 263'(1));
            checkOutput("lat_word", {out_sop, out_eop, out_empty, out_data},
                        {w == 0, w == 3, (w == 3) ? 5'd7 : 5'd0, mkData(1, w)});
        end
        checkOutput("pkt_cnt_1", 263'(pkt_cnt), 263'(1));
        drainCheck();

        $display("[TB] stray words and errored packet");
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, mkData(99, 0));
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd2, 6'd0, mkData(99, 1));
        sendPacket(2, 3, 6'h01, 5'd0, 1'b0);
        sendPacket(3, 3, 6'h00, 5'd4, 1'b1);
        idleCycles(2);
        checkOutput("drop_err_1", 263'(drop_err_cnt), 263'(1));
        checkOutput("pkt_cnt_2", 263'(pkt_cnt), 263'(2));
        drainCheck();

        $display("[TB] sop inside unterminated packet");
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 6'd0, mkData(4, 0));
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, mkData(4, 1));
        sendPacket(5, 3, 6'd0, 5'd9, 1'b1);
        idleCycles(2);
        checkOutput("drop_err_2", 263'(drop_err_cnt), 263'(2));
        checkOutput("pkt_cnt_3", 263'(pkt_cnt), 263'(3));
        drainCheck();

        $display("[TB] overflow with stalled output");
        out_ready = 1'b0;
        sendPacket(6, 70, 6'd0, 5'd0, 1'b0);
        sendPacket(7, 10, 6'd0, 5'd3, 1'b1);
        idleCycles(4);
        checkOutput("drop_ovf_1", 263'(drop_ovf_cnt), 263'(1));
        checkOutput("pkt_cnt_4", 263'(pkt_cnt), 263'(4));
        checkOutput("drop_err_same", 263'(drop_err_cnt), 263'(2));
        checkOutput("ovf_head_valid", 263'(out_valid), 263'(1));
        checkOutput("ovf_head_data", 263'(out_data), 263'(mkData(7, 0)));
        out_ready = 1'b1;
        drainCheck();

        $display("[TB] back-to-back single-word packets, toggling ready");
        toggle_mode = 1'b1;
        for (int i = 0; i < 100; i++) begin
            logic [4:0] e;
            e = 5'(i);
            applyStimulus(1'b1, 1'b1, 1'b1, e, 6'd0, mkData(300 + i, 0));
            exp_q.push_back({1'b1, 1'b1, e, mkData(300 + i, 0)});
        end
        idleCycles(100);
        toggle_mode = 1'b0;
        out_ready   = 1'b1;
        drainCheck();
        checkOutput("pkt_cnt_104", 263'(pkt_cnt), 263'(104));
        checkOutput("drop_ovf_same", 263'(drop_ovf_cnt), 263'(1));

        $display("[TB] reset mid-packet");
        out_ready = 1'b0;
        sendPacket(200, 1, 6'd0, 5'd0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0, 6'd0, mkData(201, 0));
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, mkData(201, 1));
        checkOutput("pre_rst_valid", 263'(out_valid), 263'(1));
        reset_n = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 263'(out_valid), 263'(0));
        checkOutput("mid_rst_counters", 263'({pkt_cnt, drop_err_cnt, drop_ovf_cnt}), 263'(0));
        checkOutput("mid_rst_ready", 263'(rx_ready_out), 263'(0));
        got_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 6'd0, mkData(201, 2));
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd1, 6'd0, mkData(201, 3));
        idleCycles(4);
        checkOutput("tail_pkt_cnt", 263'(pkt_cnt), 263'(0));
        checkOutput("tail_drop_err", 263'(drop_err_cnt), 263'(0));
        checkOutput("tail_out_valid", 263'(out_valid), 263'(0));
        out_ready = 1'b1;
        sendPacket(202, 2, 6'd0, 5'd1, 1'b1);
        drainCheck();
        checkOutput("post_rst_pkt_cnt", 263'(pkt_cnt), 263'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
        $finish;
    end

endmodule
